// File: rtl/i2c_slave_mem.sv
// I2C slave exposing DEPTH byte registers: a pointer byte sets the register index,
// subsequent bytes write or read with auto-increment. Open-drain SDA only, no stretching.
module i2c_slave_mem #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         DEPTH      = 16,
    parameter int         FILTER_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i2c_scl_i,
    output logic                     i2c_scl_o,
    output logic                     i2c_scl_t,
    input  logic                     i2c_sda_i,
    output logic                     i2c_sda_o,
    output logic                     i2c_sda_t,
    output logic                     busy,
    output logic                     wr_valid,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sync1, r_sync2, r_filt, r_filt_d;  // bit 0 = SCL, bit 1 = SDA
    logic [FW-1:0]   r_fcnt [2];
    logic [6:0]      r_shift;
    logic [3:0]      r_cnt;
    logic [7:0]      r_rd_byte;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_ptr, r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_sda_t, r_busy, r_wr_valid, r_rw, r_ack_on;

    logic            w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_bit8, w_hit;
    logic [7:0]      w_byte;
    logic [AW-1:0]   w_ptr_inc;

    assign i2c_scl_o = 1'b0;
    assign i2c_scl_t = 1'b1;
    assign i2c_sda_o = 1'b0;
    assign i2c_sda_t = r_sda_t;
    assign busy      = r_busy;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

    // A filtered line follows its synchronized input only after FILTER_LEN stable cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            r_sync1  <= {i2c_sda_i, i2c_scl_i};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign w_scl      = r_filt[0];
    assign w_sda      = r_filt[1];
    assign w_scl_rise = w_scl & ~r_filt_d[0];
    assign w_scl_fall = ~w_scl & r_filt_d[0];
    assign w_start    = w_scl & r_filt_d[0] & ~w_sda & r_filt_d[1];
    assign w_stop     = w_scl & r_filt_d[0] & w_sda & ~r_filt_d[1];
    assign w_byte     = {r_shift, w_sda};
    assign w_bit8     = w_scl_rise && (r_cnt == 4'd7);
    assign w_hit      = (w_byte[7:1] == DEV_ADDR);
    assign w_ptr_inc  = r_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR:     if (w_bit8) w_state_nxt = w_hit ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK: if (w_scl_fall && r_ack_on) w_state_nxt = r_rw ? S_RD_DATA : S_PTR;
                S_PTR:      if (w_bit8) w_state_nxt = S_PTR_ACK;
                S_PTR_ACK:  if (w_scl_fall && r_ack_on) w_state_nxt = S_WR_DATA;
                S_WR_DATA:  if (w_bit8) w_state_nxt = S_WR_ACK;
                S_WR_ACK:   if (w_scl_fall && r_ack_on) w_state_nxt = S_WR_DATA;
                S_RD_DATA:  if (w_scl_fall && r_cnt == 4'd8) w_state_nxt = S_RD_ACK;
                S_RD_ACK:   if (w_scl_rise) w_state_nxt = w_sda ? S_IDLE : S_RD_DATA;
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sda_t    <= 1'b1;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_ptr      <= '0;
            r_shift    <= '0;
            r_rd_byte  <= '0;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_ack_on   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_stop) begin
                r_sda_t  <= 1'b1;
                r_busy   <= 1'b0;
                r_cnt    <= '0;
                r_ack_on <= 1'b0;
            end else if (w_start) begin
                r_sda_t  <= 1'b1;
                r_cnt    <= '0;
                r_ack_on <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WR_DATA: if (w_scl_rise) begin
                        r_shift <= w_byte[6:0];
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_cnt    <= '0;
                            r_ack_on <= 1'b0;
                            if (r_state == S_ADDR) begin
                                r_busy <= w_hit;
                                r_rw   <= w_sda;
                            end else if (r_state == S_PTR) begin
                                r_ptr <= w_byte[AW-1:0];
                            end else begin
                                r_mem[r_ptr] <= w_byte;
                                r_wr_valid   <= 1'b1;
                                r_wr_addr    <= r_ptr;
                                r_wr_data    <= w_byte;
                                r_ptr        <= w_ptr_inc;
                            end
                        end
                    end
                    // First fall after the 8th bit starts the ACK, the next one ends it.
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            r_ack_on <= 1'b1;
                            r_sda_t  <= 1'b0;
                        end else begin
                            r_ack_on <= 1'b0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                r_rd_byte <= r_mem[r_ptr];
                                r_sda_t   <= r_mem[r_ptr][7];
                            end else begin
                                r_sda_t <= 1'b1;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (w_scl_rise)      r_cnt   <= r_cnt + 4'd1;
                        else if (w_scl_fall) r_sda_t <= (r_cnt == 4'd8) ? 1'b1 : r_rd_byte[~r_cnt[2:0]];
                    end
                    S_RD_ACK: if (w_scl_rise && !w_sda) begin
                        r_ptr     <= w_ptr_inc;
                        r_rd_byte <= r_mem[w_ptr_inc];
                        r_cnt     <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bit-banged I2C master driving i2c_slave_mem; results checked against a register-array model.
`timescale 1ns/1ps
module tb_i2c_slave_mem;
    localparam int H = 20;  // SCL half period in clk cycles

    logic       clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
    logic       scl_o, scl_t, sda_o, sda_t, busy, wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       scl_line, sda_line;

    assign scl_line = m_scl & (scl_t | scl_o);
    assign sda_line = m_sda & (sda_t | sda_o);

    i2c_slave_mem dut (
        .clk(clk), .rst(rst),
        .i2c_scl_i(scl_line), .i2c_scl_o(scl_o), .i2c_scl_t(scl_t),
        .i2c_sda_i(sda_line), .i2c_sda_o(sda_o), .i2c_sda_t(sda_t),
        .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    logic [7:0]  mmem [16];
    int          mptr = 0;
    logic [11:0] wq[$];
    logic [7:0]  txq[$];
    int          drive_cnt = 0, busy_cnt = 0;

    // Observed write strobes and line activity, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_valid) wq.push_back({wr_addr, wr_data});
        if (!sda_t) drive_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        m_sda = b; wait_clk(H/2);
        m_scl = 1'b1; wait_clk(H);
        m_scl = 1'b0; wait_clk(H/2);
    endtask

    task automatic bit_in(output logic b);
        m_sda = 1'b1; wait_clk(H/2);
        m_scl = 1'b1; wait_clk(H/2);
        b = sda_line; wait_clk(H/2);
        m_scl = 1'b0; wait_clk(H/2);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(H/2);
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b0; wait_clk(H);
        m_scl = 1'b0; wait_clk(H/2);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(H/2);
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b1; wait_clk(H);
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input string tag);
        logic a;
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(a);
        chk({tag, " ack"}, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic b;
        logic [7:0] v;
        v = '0;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            v[i] = b;
        end
        bit_out(mack);
        d = v;
    endtask

    // Burst write of txq starting at register pointer p.
    task automatic do_write(input logic [7:0] p, input string tag);
        int base;
        logic [11:0] exp_q[$];
        base = wq.size();
        mptr = p & 15;
        foreach (txq[i]) begin
            exp_q.push_back({mptr[3:0], txq[i]});
            mmem[mptr] = txq[i];
            mptr = (mptr + 1) % 16;
        end
        i2c_start();
        wr_byte(8'hA0, 1'b0, {tag, " addr"});
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        wr_byte(p, 1'b0, {tag, " ptr"});
        foreach (txq[i]) wr_byte(txq[i], 1'b0, {tag, " data"});
        i2c_stop();
        wait_clk(4);
        chk({tag, " wr count"}, wq.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < wq.size(); i++)
            chk({tag, " wr event"}, {20'd0, wq[base + i]}, {20'd0, exp_q[i]});
        chk({tag, " busy after stop"}, {31'd0, busy}, 32'd0);
    endtask

    // Combined read: pointer write, repeated START, n bytes (last one NACKed).
    task automatic do_read(input logic [7:0] p, input int n, input string tag);
        int base;
        logic [7:0] d;
        base = wq.size();
        i2c_start();
        wr_byte(8'hA0, 1'b0, {tag, " addr w"});
        wr_byte(p, 1'b0, {tag, " ptr"});
        i2c_start();
        wr_byte(8'hA1, 1'b0, {tag, " addr r"});
        mptr = p & 15;
        for (int i = 0; i < n; i++) begin
            rd_byte(i == n - 1, d);
            chk({tag, " rd data"}, {24'd0, d}, {24'd0, mmem[mptr]});
            if (i != n - 1) mptr = (mptr + 1) % 16;
        end
        chk({tag, " busy held after nack"}, {31'd0, busy}, 32'd1);
        i2c_stop();
        wait_clk(4);
        chk({tag, " busy after stop"}, {31'd0, busy}, 32'd0);
        chk({tag, " no wr"}, wq.size() - base, 32'd0);
    endtask

    initial begin
        int base, dc, bc, n;
        logic [7:0] p;
        for (int i = 0; i < 16; i++) mmem[i] = 8'h00;

        wait_clk(5);
        chk("rst sda_t", {31'd0, sda_t}, 32'd1);
        chk("rst scl_t", {31'd0, scl_t}, 32'd1);
        chk("rst sda_o", {31'd0, sda_o}, 32'd0);
        chk("rst scl_o", {31'd0, scl_o}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst wr_data", {24'd0, wr_data}, 32'd0);
        rst = 1'b0;
        wait_clk(2 * H);

        txq = '{8'h5A, 8'hC3};
        do_write(8'h03, "t1");
        do_read(8'h03, 2, "t2");

        dc = drive_cnt; bc = busy_cnt; base = wq.size();
        i2c_start();
        wr_byte(8'hA2, 1'b1, "t3 addr");
        wr_byte(8'h03, 1'b1, "t3 ptr");
        wr_byte(8'h77, 1'b1, "t3 data");
        i2c_stop();
        chk("t3 sda never driven", drive_cnt - dc, 32'd0);
        chk("t3 busy never set", busy_cnt - bc, 32'd0);
        chk("t3 no wr", wq.size() - base, 32'd0);
        do_read(8'h03, 2, "t3 mem");

        txq = '{8'h11, 8'h22};
        do_write(8'h0F, "t4 wrap");
        txq = '{8'h33};
        do_write(8'h1F, "t4 ptr hi");
        do_read(8'h0F, 2, "t4 rd");

        base = wq.size();
        i2c_start();
        wr_byte(8'hA0, 1'b0, "t5 addr");
        wr_byte(8'h07, 1'b0, "t5 ptr");
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        i2c_stop();
        wait_clk(4);
        chk("t5 no wr", wq.size() - base, 32'd0);
        chk("t5 busy", {31'd0, busy}, 32'd0);
        do_read(8'h07, 1, "t5 mem");
        txq = '{8'h99, 8'h42};
        do_write(8'h07, "t5 rewrite");

        for (int it = 0; it < 5; it++) begin
            txq.delete();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) txq.push_back(8'($urandom_range(0, 255)));
            p = 8'($urandom_range(0, 255));
            do_write(p, "rnd wr");
            p = 8'($urandom_range(0, 255));
            do_read(p, $urandom_range(1, 3), "rnd rd");
        end

        txq = '{8'h5A};
        do_write(8'h03, "t6 prep");
        i2c_start();
        wr_byte(8'hA0, 1'b0, "t6 addr w");
        wr_byte(8'h03, 1'b0, "t6 ptr");
        i2c_start();
        wr_byte(8'hA1, 1'b0, "t6 addr r");
        chk("t6 driving 0 bit", {31'd0, sda_t}, 32'd0);
        rst = 1'b1;
        wait_clk(1);
        chk("t6 sda released", {31'd0, sda_t}, 32'd1);
        chk("t6 busy", {31'd0, busy}, 32'd0);
        chk("t6 wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("t6 wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("t6 wr_data", {24'd0, wr_data}, 32'd0);
        wait_clk(2);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b1; wait_clk(2 * H);
        i2c_start();
        wr_byte(8'hA0, 1'b0, "t6 new addr");
        chk("t6 busy after ack", {31'd0, busy}, 32'd1);
        i2c_stop();
        do_read(8'h03, 2, "t6 mem cleared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_slave_mem.md
# i2c_slave_mem

Synthesizable I2C slave with a small byte-addressed register memory. It sits on the far side of the I2C bus from `i2c_master_wbs_8`, on the shared open-drain SCL/SDA lines, and is the target device for that master in the i2c testbench. It detects START and STOP conditions, matches a 7-bit device address, and accepts a register-pointer byte followed by write data. It returns read data with pointer auto-increment.

## Interface
Parameters:
- `DEV_ADDR`, 7'h50: 7-bit slave address.
- `DEPTH`, 16: number of 8-bit registers; power of two, 2..256.
- `FILTER_LEN`, 4: glitch-filter length in clk cycles for SCL/SDA.

Ports:
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `i2c_scl_i` in 1: SCL line level.
- `i2c_scl_o` out 1: SCL drive value; constant 0.
- `i2c_scl_t` out 1: SCL tristate; constant 1 (released). No clock stretching.
- `i2c_sda_i` in 1: SDA line level.
- `i2c_sda_o` out 1: SDA drive value; constant 0.
- `i2c_sda_t` out 1: SDA tristate. 1 = released, 0 = pull low.
- `busy` out 1: high from the address match until STOP or a NACKed address.
- `wr_valid` out 1: one-cycle pulse when a data byte has been written to memory.
- `wr_addr` out $clog2(DEPTH): register index of the last write.
- `wr_data` out 8: data of the last write.

## Operation
**Input conditioning**
- 2-flop synchronizer on `i2c_scl_i` and `i2c_sda_i`.
- Each filtered level changes only after the synchronized input has been stable for `FILTER_LEN` consecutive cycles.
- Edge/condition detection uses filtered levels only:
  - `scl_rise`, `scl_fall`.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.

**Shift and bit timing**
- 8-bit shift register, MSB first.
- Bits are sampled on `scl_rise`.
- SDA drive changes only on the cycle after `scl_fall`.

**States**
- IDLE
  - START → ADDR; bit counter cleared.
- ADDR
  - After 8 bits: if addr[7:1] == `DEV_ADDR`, go to ADDR_ACK and set `busy`. The R/W bit is latched.
  - Otherwise go to IDLE (SDA stays released = NACK).
- ADDR_ACK
  - Drive SDA low for one SCL pulse.
  - Then: write → PTR; read → RD_DATA with `rd_byte = mem[ptr]`.
- PTR
  - 8 bits received; `ptr = byte[$clog2(DEPTH)-1:0]` (upper bits ignored).
  - → PTR_ACK (ACK) → WR_DATA.
- WR_DATA
  - 8 bits received: `mem[ptr] = byte`, pulse `wr_valid`, update `wr_addr`/`wr_data`, `ptr++`.
  - → WR_ACK (ACK) → WR_DATA.
- RD_DATA
  - Drive each bit as `sda_t = rd_byte[bit]`.
  - After 8 bits → RD_ACK, with SDA released.
- RD_ACK
  - Sample master ACK on `scl_rise`.
  - ACK (0): `ptr++`, `rd_byte = mem[ptr]`, → RD_DATA.
  - NACK (1): → IDLE; `busy` is held until STOP.

**Pointer**
- Increments modulo `DEPTH`: DEPTH-1 wraps to 0.

**Bus conditions (any state)**
- START: → ADDR (repeated start); `ptr` is preserved.
- STOP: → IDLE; `busy` = 0; SDA released. A partially received byte is discarded (no write).

## Timing
**Reset values**
- All state cleared: `i2c_sda_t` = 1, `i2c_sda_o` = 0, `i2c_scl_t` = 1, `i2c_scl_o` = 0.
- `busy` = 0, `wr_valid` = 0, `wr_addr` = 0, `wr_data` = 0, `ptr` = 0, all memory = 0, state = IDLE.
- Reset mid-transfer releases SDA on the next cycle and ignores the bus until the next START.

**Input latency**
- Pin to filtered level: 2 + `FILTER_LEN` cycles.
- Minimum SCL high/low time supported: `FILTER_LEN` + 4 clk cycles.

**SDA drive**
- ACK/data is driven 1 cycle after filtered `scl_fall`.
- It is released 1 cycle after the `scl_fall` that ends the ACK/bit.
- SDA is never changed while filtered SCL is high.

**Write strobe**
- `wr_valid` asserts the cycle after `scl_rise` of bit 0 of a data byte.
- It is exactly one cycle wide.

**Simultaneous events**
- START/STOP detection takes priority over bit sampling on the same cycle.

## Test plan
1. Write burst: START, 0xA0, 0x03, 0x5A, 0xC3, STOP.
   - Expect ACK after each byte.
   - Expect `wr_valid` pulses with (3, 0x5A) then (4, 0xC3).
   - Expect mem[3] = 0x5A, mem[4] = 0xC3, and `busy` low after STOP.
2. Combined read: START, 0xA0, 0x03, Sr, 0xA1; read two bytes (master ACK, then NACK); STOP.
   - Expect data 0x5A then 0xC3, with no `wr_valid`.
3. Address mismatch: START, 0xA2, ...
   - Expect `i2c_sda_t` = 1 throughout (NACK), `busy` = 0, memory unchanged.
4. Pointer wrap: write pointer 0x0F, then data 0x11, 0x22.
   - Expect mem[15] = 0x11, mem[0] = 0x22.
   - Pointer byte 0x1F with DEPTH = 16 also selects register 15.
5. Abort: STOP after 4 data bits.
   - Expect no `wr_valid`, memory unchanged, IDLE.
   - A subsequent full write succeeds.
6. Reset mid-read: assert `rst` while the slave drives a 0 data bit.
   - Expect `i2c_sda_t` = 1 on the next cycle and all outputs at reset values.
   - A new START/address is ACKed.
